mux_scan_ctrl: RTL and testbench

Scan controller for the five-channel 3-bit select/7-segment display path. It steps the 3-bit select through channels u, v, w, x, y (0..4), either automatically with a programmable dwell or one channel per requester handshake. On each visit it snapshots the selected channel and drives a registered 7-segment pattern, so the display stays stable while inputs change.

---
 rtl/mux_scan_pkg.sv | 29 ++
 rtl/seg7_dec.sv | 24 ++
 rtl/mux_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the five-channel select / 7-segment scan path.
// Segment patterns are active-high with bit order {g,f,e,d,c,b,a}.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int              NUM_CH   = 5;
  localparam int              SEL_W    = 3;
  localparam logic [SEL_W-1:0] SEL_LAST = 3'd4;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;

  // Wraps after the last channel so select never leaves 0..4.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return (s == SEL_LAST) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 3-bit value to 7-segment pattern decoder.
// Output is registered by the instantiating controller.
module seg7_dec
  import mux_scan_pkg::*;
(
  input  logic [2:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (val)
      3'd0: seg = SEG_0;
      3'd1: seg = SEG_1;
      3'd2: seg = SEG_2;
      3'd3: seg = SEG_3;
      3'd4: seg = SEG_4;
      3'd5: seg = SEG_5;
      3'd6: seg = SEG_6;
      3'd7: seg = SEG_7;
    endcase
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps select over five channels (auto dwell or manual handshake),
// snapshots the selected channel and drives a registered 7-segment pattern.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               step_req,
  output logic               step_ack,
  input  logic [SEL_W-1:0]   u,
  input  logic [SEL_W-1:0]   v,
  input  logic [SEL_W-1:0]   w,
  input  logic [SEL_W-1:0]   x,
  input  logic [SEL_W-1:0]   y,
  output logic [SEL_W-1:0]   sel,
  output logic [SEL_W-1:0]   digit,
  output logic [6:0]         led7_out,
  output logic               ch_valid,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   digit_q, digit_d;
  logic [6:0]         led_q, led_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               step_ack_q, step_ack_d;
  logic               ch_valid_q, ch_valid_d;
  logic               wrap_q, wrap_d;
  logic               advance;

  logic [SEL_W-1:0]   ch [NUM_CH];
  logic [SEL_W-1:0]   mux_val;
  logic [6:0]         mux_seg;

  assign ch[0] = u;
  assign ch[1] = v;
  assign ch[2] = w;
  assign ch[3] = x;
  assign ch[4] = y;

  always_comb begin
    mux_val = '0;
    if (sel_q <= SEL_LAST) mux_val = ch[sel_q];
  end

  seg7_dec u_seg7_dec (
    .val (mux_val),
    .seg (mux_seg)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    digit_d    = digit_q;
    led_d      = led_q;
    cnt_d      = cnt_q;
    // Re-arming happens on any low cycle of the request, whatever the state.
    armed_d    = armed_q | ~step_req;
    step_ack_d = 1'b0;
    ch_valid_d = 1'b0;
    wrap_d     = 1'b0;
    advance    = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SETTLE;
        SETTLE: begin
          digit_d    = mux_val;
          led_d      = mux_seg;
          ch_valid_d = 1'b1;
          cnt_d      = (dwell == '0) ? DWELL_W'(1) : dwell;
          state_d    = HOLD;
        end
        HOLD: begin
          if (!mode) begin
            if (cnt_q <= DWELL_W'(1)) advance = 1'b1;
            else                      cnt_d   = cnt_q - DWELL_W'(1);
          end else if (step_req && armed_q) begin
            step_ack_d = 1'b1;
            armed_d    = 1'b0;
            advance    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (advance) begin
      sel_d   = next_sel(sel_q);
      wrap_d  = (sel_q == SEL_LAST);
      state_d = SETTLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      digit_q    <= '0;
      led_q      <= SEG_0;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      step_ack_q <= 1'b0;
      ch_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      digit_q    <= digit_d;
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      step_ack_q <= step_ack_d;
      ch_valid_q <= ch_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign sel      = sel_q;
  assign digit    = digit_q;
  assign led7_out = led_q;
  assign step_ack = step_ack_q;
  assign ch_valid = ch_valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: channel visits are queued as expected
// {sel,digit,segments} and popped whenever ch_valid is observed.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] dwell = 8'd1;
  logic       step_req = 1'b0;
  logic       step_ack;
  logic [2:0] u = 3'd0, v = 3'd0, w = 3'd0, x = 3'd0, y = 3'd0;
  logic [2:0] sel, digit;
  logic [6:0] led7_out;
  logic       ch_valid, wrap;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
    .step_req(step_req), .step_ack(step_ack),
    .u(u), .v(v), .w(w), .x(x), .y(y),
    .sel(sel), .digit(digit), .led7_out(led7_out),
    .ch_valid(ch_valid), .wrap(wrap)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] digit;
    logic [6:0] led;
  } visit_t;

  visit_t     sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [2:0] prev_sel = 3'd0;
  bit         sel_changed = 1'b0;

  function automatic logic [6:0] seg_exp(input logic [2:0] d);
    case (d)
      3'd0: return 7'b0111111;
      3'd1: return 7'b0000110;
      3'd2: return 7'b1011011;
      3'd3: return 7'b1001111;
      3'd4: return 7'b1100110;
      3'd5: return 7'b1101101;
      3'd6: return 7'b1111101;
      default: return 7'b0000111;
    endcase
  endfunction

  function automatic logic [2:0] ch_val(input logic [2:0] s);
    case (s)
      3'd0: return u;
      3'd1: return v;
      3'd2: return w;
      3'd3: return x;
      default: return y;
    endcase
  endfunction

  task automatic push_visit(input logic [2:0] s);
    visit_t e;
    e.sel   = s;
    e.digit = ch_val(s);
    e.led   = seg_exp(ch_val(s));
    sb.push_back(e);
  endtask

  // One clock; samples 1 time unit after the edge and retires a visit on ch_valid.
  task automatic tick();
    visit_t e;
    @(posedge clk);
    #1;
    cyc++;
    sel_changed = (sel !== prev_sel);
    prev_sel = sel;
    if (ch_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL visit_unexpected: got sel=%0d digit=%0d seg=%b, expected no ch_valid", sel, digit, led7_out);
      end else begin
        e = sb.pop_front();
        if ({sel, digit, led7_out} !== e) begin
          errors++;
          $display("FAIL visit: got sel=%0d digit=%0d seg=%b, expected sel=%0d digit=%0d seg=%b",
                   sel, digit, led7_out, e.sel, e.digit, e.led);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d visits pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    step_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_sel = sel;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++;
    if (digit !== 3'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
    checks++;
    if (led7_out !== 7'b0111111) begin errors++; $display("FAIL reset_seg: got %b expected 0111111", led7_out); end
    checks++;
    if ({step_ack, ch_valid, wrap} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {step_ack, ch_valid, wrap});
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sel = sel;
    $display("test_reset done");
  endtask

  task automatic test_auto_scan();
    int last = -1, nwrap = 0, nvalid = 0, n = 0;
    do_reset();
    u = 3'd1; v = 3'd2; w = 3'd3; x = 3'd4; y = 3'd5;
    dwell = 8'd3;
    for (int s = 0; s < 5; s++) push_visit(3'(s));
    push_visit(3'd0);
    en = 1'b1;
    while (sb.size() > 0 && n < 80) begin
      tick();
      n++;
      if (ch_valid === 1'b1) nvalid++;
      if (wrap === 1'b1) begin
        nwrap++;
        checks++;
        if (sel !== 3'd0 || !sel_changed) begin
          errors++; $display("FAIL auto_wrap_sel: got sel=%0d changed=%0d expected sel=0 changed=1", sel, sel_changed);
        end
      end
      if (sel_changed) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 4) begin errors++; $display("FAIL auto_period: got %0d expected 4", cyc - last); end
        end
        last = cyc;
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL auto_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
    checks++;
    if (nwrap !== 1) begin errors++; $display("FAIL auto_wrap_count: got %0d expected 1", nwrap); end
    checks++;
    if (nvalid !== 6) begin errors++; $display("FAIL auto_valid_count: got %0d expected 6", nvalid); end
    $display("test_auto_scan done: %0d visits", nvalid);
  endtask

  task automatic test_zero_dwell();
    int last = -1, n = 0;
    do_reset();
    u = 3'd6; v = 3'd7; w = 3'd0; x = 3'd1; y = 3'd2;
    dwell = 8'd0;
    for (int s = 0; s < 4; s++) push_visit(3'(s));
    en = 1'b1;
    while (sb.size() > 0 && n < 40) begin
      tick();
      n++;
      if (sel_changed) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 2) begin errors++; $display("FAIL zero_dwell_period: got %0d expected 2", cyc - last); end
        end
        last = cyc;
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL zero_dwell_timeout: got %0d pending expected 0", sb.size()); sb.delete(); end
    $display("test_zero_dwell done");
  endtask

  task automatic test_manual();
    int nack;
    logic [2:0] tgt [3];
    tgt[0] = 3'd3; tgt[1] = 3'd4; tgt[2] = 3'd0;
    do_reset();
    u = 3'd1; v = 3'd2; w = 3'd3; x = 3'd4; y = 3'd5;
    dwell = 8'd2;
    mode = 1'b1;
    push_visit(3'd0);
    en = 1'b1;
    drain(10);

    push_visit(3'd1);
    step_req = 1'b1;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (step_ack === 1'b1) begin
        nack++;
        checks++;
        if (sel !== 3'd1) begin errors++; $display("FAIL manual_ack_sel: got %0d expected 1", sel); end
      end
    end
    checks++;
    if (nack !== 1) begin errors++; $display("FAIL manual_held_acks: got %0d expected 1", nack); end
    checks++;
    if (sel !== 3'd1) begin errors++; $display("FAIL manual_held_sel: got %0d expected 1", sel); end

    step_req = 1'b0;
    tick();
    push_visit(3'd2);
    step_req = 1'b1;
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (step_ack === 1'b1) nack++;
    end
    checks++;
    if (nack !== 1 || sel !== 3'd2) begin
      errors++; $display("FAIL manual_second: got acks=%0d sel=%0d expected acks=1 sel=2", nack, sel);
    end

    for (int i = 0; i < 3; i++) begin
      int n = 0;
      step_req = 1'b0;
      tick();
      push_visit(tgt[i]);
      step_req = 1'b1;
      do begin
        tick();
        n++;
      end while (step_ack !== 1'b1 && n < 5);
      checks++;
      if (step_ack !== 1'b1 || sel !== tgt[i] || wrap !== (tgt[i] == 3'd0)) begin
        errors++;
        $display("FAIL manual_step: got ack=%0d sel=%0d wrap=%0d expected ack=1 sel=%0d wrap=%0d",
                 step_ack, sel, wrap, tgt[i], (tgt[i] == 3'd0));
      end
    end
    step_req = 1'b0;
    drain(5);
    $display("test_manual done");
  endtask

  task automatic test_snapshot();
    do_reset();
    u = 3'd1; v = 3'd2; w = 3'd3; x = 3'd4; y = 3'd5;
    dwell = 8'd10;
    push_visit(3'd0);
    en = 1'b1;
    drain(10);
    u = 3'd7;
    repeat (3) tick();
    checks++;
    if (digit !== 3'd1 || led7_out !== 7'b0000110) begin
      errors++; $display("FAIL snapshot_hold: got digit=%0d seg=%b expected digit=1 seg=0000110", digit, led7_out);
    end
    for (int s = 1; s < 5; s++) push_visit(3'(s));
    push_visit(3'd0);
    drain(100);
    checks++;
    if (digit !== 3'd7 || led7_out !== 7'b0000111) begin
      errors++; $display("FAIL snapshot_revisit: got digit=%0d seg=%b expected digit=7 seg=0000111", digit, led7_out);
    end
    $display("test_snapshot done");
  endtask

  task automatic test_enable_drop();
    int n;
    do_reset();
    u = 3'd3; v = 3'd5; w = 3'd2; x = 3'd6; y = 3'd4;
    dwell = 8'd5;
    for (int s = 0; s < 3; s++) push_visit(3'(s));
    en = 1'b1;
    drain(40);
    repeat (2) tick();
    en = 1'b0;
    tick();
    checks++;
    if (sel !== 3'd2 || digit !== 3'd2 || led7_out !== 7'b1011011 || {ch_valid, wrap, step_ack} !== 3'b000) begin
      errors++; $display("FAIL en_drop_hold: got sel=%0d digit=%0d seg=%b expected sel=2 digit=2 seg=1011011", sel, digit, led7_out);
    end
    w = 3'd7;
    repeat (3) tick();
    checks++;
    if (sel !== 3'd2 || digit !== 3'd2 || led7_out !== 7'b1011011) begin
      errors++; $display("FAIL en_idle_hold: got sel=%0d digit=%0d seg=%b expected sel=2 digit=2 seg=1011011", sel, digit, led7_out);
    end
    push_visit(3'd2);
    en = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2 || sb.size() != 0) begin
      errors++; $display("FAIL en_restart_latency: got %0d cycles expected 2", n);
      sb.delete();
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!sel_changed && n < 20);
    checks++;
    if (n !== 5 || sel !== 3'd3) begin
      errors++; $display("FAIL en_full_dwell: got %0d cycles sel=%0d expected 5 cycles sel=3", n, sel);
    end
    $display("test_enable_drop done");
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    u = 3'd5; v = 3'd6; w = 3'd7; x = 3'd1; y = 3'd2;
    dwell = 8'd2;
    for (int s = 0; s < 3; s++) push_visit(3'(s));
    en = 1'b1;
    repeat (7) tick();
    checks++;
    if (sel !== 3'd2) begin errors++; $display("FAIL mid_scan_pre: got sel=%0d expected 2", sel); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sel !== 3'd0 || digit !== 3'd0 || led7_out !== 7'b0111111 || {step_ack, ch_valid, wrap} !== 3'b000) begin
      errors++; $display("FAIL async_reset: got sel=%0d digit=%0d seg=%b pulses=%b expected 0 0 0111111 000",
                         sel, digit, led7_out, {step_ack, ch_valid, wrap});
    end
    sb.delete();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset_mid_scan done");
  endtask

  initial begin
    test_reset();
    test_auto_scan();
    test_zero_dwell();
    test_manual();
    test_snapshot();
    test_enable_drop();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
